mod_txt_mem_p: RTL and testbench

MOD_TXT_MEM_P -- requirements
Module: mod_txt_mem_p

---
 rtl/mod_txt_mem_p.sv | 238 +++++++++++++++++++++++
 tb/tb_mod_txt_mem_p.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_txt_mem_p.sv
// Text-mode screen memory: banked cell RAM shared by the display scan and a
// 4-state bus read FSM, control registers, and a glyph font path (ROMs + RAM).
// Optional macro TXTMEM_CTRL_SHADOW_EN: CR0..CR7 writes land in shadows that
// are copied to the active registers on frameSync.
module mod_txt_mem_p #(
   parameter int         CELL_BITS  = 256,
   parameter int         DEPTH_LOG2 = 10,
   parameter logic [8:0] REG_BASE   = 9'h1FF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [13:0]          pixCellIx,
   output logic [CELL_BITS-1:0] cellData,
   input  logic [15:0]          fontGlyph,
   output logic [63:0]          fontData,
   output logic [63:0]          ctrlRegVal,
   input  logic                 frameSync,
   input  logic [31:0]          busAddr,
   input  logic [63:0]          busInData,
   output logic [63:0]          busOutData,
   input  logic                 busOE,
   input  logic                 busWR,
   input  logic                 busQW,
   output logic [1:0]           busOK
);
   localparam int LANES = CELL_BITS / 32;
   localparam int BOFS  = $clog2(CELL_BITS / 8);
   localparam int LW    = BOFS - 2;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_READY = 2'd3;

   logic                  sel, reg_win, cell_rd, wr_go, fwe;
   logic [7:0]            reg_off;
   logic [LW-1:0]         bus_lane, rd_lane;
   logic [DEPTH_LOG2-1:0] bus_cell, port_cell;
   logic [1:0]            fplane;

   logic [1:0]            state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic                  qw_q, qw_d, reg_ok_q, reg_ok_d, wr_ok_q, wr_ok_d;
   logic                  disp_vld_q, disp_vld_d;
   logic [63:0]           rd_data_q, rd_data_d, lane_data;
   logic [CELL_BITS-1:0]  cell_q, cell_d;
   logic [7:0][31:0]      cr_q, cr_d, cr_rd;
   logic [31:0]           cr9_q, cr9_d, reg_rd;
   logic [2:0]            fsel_q, fsel_d;
   logic [63:0]           rom_q, rom_d, font_q, font_d, font_ram_rd;
   logic [LANES-1:0][31:0] ram_rd;
`ifdef TXTMEM_CTRL_SHADOW_EN
   logic [7:0][31:0]      crs_q, crs_d;
`endif

   assign sel       = (busAddr[27:16] == 12'h00A) || (busAddr[27:16] == 12'h00B);
   assign reg_win   = sel && (busAddr[16:8] == REG_BASE);
   assign cell_rd   = busOE && sel && !reg_win;
   assign reg_off   = busAddr[7:0];
   assign bus_lane  = busAddr[BOFS-1:2];
   assign bus_cell  = busAddr[BOFS +: DEPTH_LOG2];
   // A held write commits once; nothing commits while reset is asserted.
   assign wr_go     = busWR && !busOE && sel && !wr_ok_q && reset;
   assign fwe       = wr_go && reg_win && (reg_off[7:4] == 4'h3);
   assign fplane    = reg_off[3:2];
   // The bus fetch steals the single read port from the display scan.
   assign port_cell = (state_q == S_FETCH) ? addr_q[BOFS +: DEPTH_LOG2]
                                           : pixCellIx[DEPTH_LOG2-1:0];
   assign rd_lane   = addr_q[BOFS-1:2];

   genvar gi;
   for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LW-1:0] LI = LW'(gi);
      logic [31:0] mem [DEPTH];
      logic [31:0] wd, rd_q;
      logic        we;
      assign we = wr_go && !reg_win &&
                  (busQW ? (LI[LW-1:1] == bus_lane[LW-1:1]) : (LI == bus_lane));
      assign wd = (busQW && LI[0]) ? busInData[63:32] : busInData[31:0];
      // One synchronous write port and one registered read port per lane bank
      always_ff @(posedge clock) begin
         if (we) mem[bus_cell] <= wd;
         rd_q <= mem[port_cell];
      end
      assign ram_rd[gi] = rd_q;
   end

   genvar gp;
   for (gp = 0; gp < 4; gp++) begin : g_plane
      localparam logic [1:0] PI = 2'(gp);
      logic [15:0] fmem [512];
      logic [15:0] rd_q;
      // Font RAM is written one 16-bit plane at a time
      always_ff @(posedge clock) begin
         if (fwe && (fplane == PI)) fmem[busInData[24:16]] <= busInData[15:0];
         rd_q <= fmem[fontGlyph[8:0]];
      end
      assign font_ram_rd[gp*16 +: 16] = rd_q;
   end

   // Built-in glyph sets are generated from the index rather than tabulated.
   function automatic logic [63:0] rom_glyph(input logic [2:0] src, input logic [7:0] ix);
      casez (src)
         3'b00?:  rom_glyph = {4{ix, ~ix}};
         3'b010:  rom_glyph = {8{1'b0, ix[6:0]}};
         3'b011:  rom_glyph = {8{1'b1, ix[6:0]}};
         default: rom_glyph = 64'h0;
      endcase
   endfunction

`ifdef TXTMEM_CTRL_SHADOW_EN
   assign cr_rd = crs_q;
`else
   assign cr_rd = cr_q;
`endif

   // Register-window read mux and lane extraction for cell reads
   always_comb begin
      reg_rd = 32'h0;
      if (reg_off[7:5] == 3'b000)  reg_rd = cr_rd[reg_off[4:2]];
      else if (reg_off == 8'h20)   reg_rd = {18'h0, pixCellIx};
      else if (reg_off == 8'h24)   reg_rd = cr9_q;
      if (qw_q) lane_data = {ram_rd[{rd_lane[LW-1:1], 1'b1}], ram_rd[{rd_lane[LW-1:1], 1'b0}]};
      else      lane_data = {32'h0, ram_rd[rd_lane]};
   end

   // Bus read FSM, register reads and write acknowledge
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      qw_d      = qw_q;
      rd_data_d = rd_data_q;
      case (state_q)
         S_IDLE:  if (cell_rd) state_d = S_FETCH;
         S_FETCH: state_d = busOE ? S_WAIT : S_IDLE;
         S_WAIT: begin
            if (busOE) begin
               state_d   = S_READY;
               rd_data_d = lane_data;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READY: begin
            if (!busOE) state_d = S_IDLE;
            else if ({busAddr, busQW} != {addr_q, qw_q}) state_d = cell_rd ? S_FETCH : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_FETCH) begin
         addr_d = busAddr;
         qw_d   = busQW;
      end
      reg_ok_d = busOE && reg_win && (state_q == S_IDLE);
      if (reg_ok_d) rd_data_d = {32'h0, reg_rd};
      wr_ok_d = busWR && !busOE && sel;
   end

   // Control registers; shadows are applied on frameSync when enabled
   always_comb begin
      cr_d  = cr_q;
      cr9_d = cr9_q;
`ifdef TXTMEM_CTRL_SHADOW_EN
      crs_d = crs_q;
      if (frameSync) cr_d = crs_q;
`endif
      if (wr_go && reg_win) begin
         if (reg_off[7:5] == 3'b000) begin
`ifdef TXTMEM_CTRL_SHADOW_EN
            crs_d[reg_off[4:2]] = busInData[31:0];
`else
            cr_d[reg_off[4:2]] = busInData[31:0];
`endif
         end else if (reg_off == 8'h24) begin
            cr9_d = busInData[31:0];
         end
      end
   end

   // Display and font pipelines; display holds when the port was stolen
   always_comb begin
      disp_vld_d = (state_q != S_FETCH);
      cell_d     = disp_vld_q ? ram_rd : cell_q;
      fsel_d     = fontGlyph[9:7];
      rom_d      = rom_glyph(fontGlyph[9:7], fontGlyph[7:0]);
      font_d     = fsel_q[2] ? font_ram_rd : rom_q;
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         qw_q       <= 1'b0;
         reg_ok_q   <= 1'b0;
         wr_ok_q    <= 1'b0;
         disp_vld_q <= 1'b0;
         rd_data_q  <= '0;
         cell_q     <= '0;
         cr_q       <= '0;
         cr9_q      <= '0;
         fsel_q     <= '0;
         rom_q      <= '0;
         font_q     <= '0;
`ifdef TXTMEM_CTRL_SHADOW_EN
         crs_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         qw_q       <= qw_d;
         reg_ok_q   <= reg_ok_d;
         wr_ok_q    <= wr_ok_d;
         disp_vld_q <= disp_vld_d;
         rd_data_q  <= rd_data_d;
         cell_q     <= cell_d;
         cr_q       <= cr_d;
         cr9_q      <= cr9_d;
         fsel_q     <= fsel_d;
         rom_q      <= rom_d;
         font_q     <= font_d;
`ifdef TXTMEM_CTRL_SHADOW_EN
         crs_q      <= crs_d;
`endif
      end
   end

   assign busOK = ((state_q == S_FETCH) || (state_q == S_WAIT)) ? 2'b10 :
                  ((state_q == S_READY) || reg_ok_q || wr_ok_q) ? 2'b01 : 2'b00;
   assign busOutData = rd_data_q;
   assign cellData   = cell_q;
   assign fontData   = font_q;
   assign ctrlRegVal = {cr_q[1], cr_q[0]};

   logic unused_bits;
   assign unused_bits = ^{busAddr, fontGlyph, frameSync, pixCellIx, cr_q};
endmodule

// File: tb/tb_mod_txt_mem_p.sv
// Scoreboard bench for mod_txt_mem_p: expected bus read data is queued when a
// read is issued and popped when the DUT reports busOK=01.
module tb_mod_txt_mem_p;
   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [13:0]  pixCellIx = '0;
   logic [255:0] cellData;
   logic [15:0]  fontGlyph = '0;
   logic [63:0]  fontData, ctrlRegVal, busOutData;
   logic         frameSync = 1'b0;
   logic [31:0]  busAddr = '0;
   logic [63:0]  busInData = '0;
   logic         busOE = 1'b0, busWR = 1'b0, busQW = 1'b0;
   logic [1:0]   busOK;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];

   mod_txt_mem_p dut (
      .clock(clock), .reset(reset), .pixCellIx(pixCellIx), .cellData(cellData),
      .fontGlyph(fontGlyph), .fontData(fontData), .ctrlRegVal(ctrlRegVal),
      .frameSync(frameSync), .busAddr(busAddr), .busInData(busInData),
      .busOutData(busOutData), .busOE(busOE), .busWR(busWR), .busQW(busQW),
      .busOK(busOK)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic bus_write(input logic [31:0] a, input logic [63:0] d, input logic qw,
                            output logic acked);
      @(negedge clock);
      busAddr = a; busInData = d; busQW = qw; busOE = 1'b0; busWR = 1'b1;
      acked = 1'b0;
      for (int i = 0; i < 4 && !acked; i++) begin
         @(negedge clock);
         if (busOK == 2'b01) acked = 1'b1;
      end
      busWR = 1'b0;
      @(negedge clock);
   endtask

   // Leaves busOE high; returns on the negedge where busOK=01 was seen.
   task automatic bus_read(input logic [31:0] a, input logic qw,
                           output logic [63:0] d, output int waits, output logic got);
      @(negedge clock);
      busAddr = a; busQW = qw; busWR = 1'b0; busOE = 1'b1;
      waits = 0; got = 1'b0; d = '0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clock);
         if (busOK == 2'b01) begin got = 1'b1; d = busOutData; end
         else if (busOK == 2'b10) waits++;
      end
   endtask

   task automatic bus_release(output logic [1:0] ok);
      busOE = 1'b0;
      @(negedge clock);
      ok = busOK;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (busOK !== 2'b00) begin errors++; $display("FAIL reset_busok got=%b exp=00", busOK); end
      checks++; if (busOutData !== 64'h0) begin errors++; $display("FAIL reset_busout got=%h exp=0", busOutData); end
      checks++; if (cellData !== 256'h0) begin errors++; $display("FAIL reset_cell got=%h exp=0", cellData); end
      checks++; if (fontData !== 64'h0) begin errors++; $display("FAIL reset_font got=%h exp=0", fontData); end
      checks++; if (ctrlRegVal !== 64'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", ctrlRegVal); end
      reset = 1'b1;
   endtask

   task automatic test_qw();
      logic acked, got; logic [63:0] d, exp; int waits; logic [1:0] ok;
      bus_write(32'h000A0008, 64'h1122334455667788, 1'b1, acked);
      checks++; if (acked !== 1'b1) begin errors++; $display("FAIL qw_write_ack got=%b exp=1", acked); end
      exp_q.push_back(64'h1122334455667788);
      bus_read(32'h000A0008, 1'b1, d, waits, got);
      exp = exp_q.pop_front();
      checks++; if (!got || d !== exp) begin errors++; $display("FAIL qw_read got=%h (ok=%b) exp=%h", d, got, exp); end
      checks++; if (waits != 2) begin errors++; $display("FAIL qw_hold_cycles got=%0d exp=2", waits); end
      @(negedge clock);
      checks++; if (busOK !== 2'b01 || busOutData !== exp) begin
         errors++; $display("FAIL qw_ready_hold got=%b/%h exp=01/%h", busOK, busOutData, exp); end
      bus_release(ok);
      checks++; if (ok !== 2'b00) begin errors++; $display("FAIL qw_release got=%b exp=00", ok); end
   endtask

   task automatic test_dw();
      logic a1, a2, got; logic [63:0] d, exp; int waits; logic [1:0] ok;
      logic [31:0] addrs [3] = '{32'h000A0014, 32'h000A0008, 32'h000A0010};
      logic        qws   [3] = '{1'b0, 1'b1, 1'b1};
      logic [63:0] exps  [3] = '{64'h00000000DEADBEEF, 64'h1122334455667788, 64'hDEADBEEFCAFEF00D};
      bus_write(32'h000A0014, 64'h99999999DEADBEEF, 1'b0, a1);
      bus_write(32'h000A0010, 64'h00000000CAFEF00D, 1'b0, a2);
      checks++; if (!(a1 && a2)) begin errors++; $display("FAIL dw_write_ack got=%b%b exp=11", a1, a2); end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(exps[i]);
         bus_read(addrs[i], qws[i], d, waits, got);
         exp = exp_q.pop_front();
         checks++; if (!got || d !== exp) begin
            errors++; $display("FAIL dw_read[%0d] got=%h (ok=%b) exp=%h", i, d, got, exp); end
         bus_release(ok);
      end
      pixCellIx = 14'd0;
      repeat (3) @(negedge clock);
      checks++; if (cellData[191:64] !== 128'hDEADBEEF_CAFEF00D_11223344_55667788) begin
         errors++; $display("FAIL display_cell got=%h exp=deadbeefcafef00d1122334455667788", cellData[191:64]); end
   endtask

   task automatic test_back_to_back();
      logic got; logic [63:0] d, exp; int waits; logic [1:0] ok;
      @(negedge clock);
      busAddr = 32'h000A0028; busInData = 64'h0BADF00D600DCAFE; busQW = 1'b1; busWR = 1'b1; busOE = 1'b0;
      @(negedge clock);
      busWR = 1'b0; busOE = 1'b1;
      exp_q.push_back(64'h0BADF00D600DCAFE);
      waits = 0; got = 1'b0; d = '0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clock);
         if (busOK == 2'b01) begin got = 1'b1; d = busOutData; end else if (busOK == 2'b10) waits++;
      end
      exp = exp_q.pop_front();
      checks++; if (!got || d !== exp) begin errors++; $display("FAIL raw_read got=%h (ok=%b) exp=%h", d, got, exp); end
      checks++; if (waits != 2) begin errors++; $display("FAIL raw_hold_cycles got=%0d exp=2", waits); end
      // Address change while READY restarts the fetch
      busAddr = 32'h000A0008;
      exp_q.push_back(64'h1122334455667788);
      waits = 0; got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clock);
         if (busOK == 2'b01) begin got = 1'b1; d = busOutData; end else if (busOK == 2'b10) waits++;
      end
      exp = exp_q.pop_front();
      checks++; if (!got || d !== exp || waits != 2) begin
         errors++; $display("FAIL readdr_read got=%h waits=%0d exp=%h waits=2", d, waits, exp); end
      bus_release(ok);
      checks++; if (ok !== 2'b00) begin errors++; $display("FAIL readdr_release got=%b exp=00", ok); end
   endtask

   task automatic test_ctrl();
      logic a, got; logic [63:0] d, exp; int waits; logic [1:0] ok;
      logic [31:0] raddr [4] = '{32'h000BFF00, 32'h000BFF24, 32'h000BFF20, 32'h000BFF28};
      logic [63:0] rexp  [4] = '{64'h5, 64'hA5A5, 64'h1234, 64'h0};
      bus_write(32'h000BFF00, 64'h5, 1'b0, a);
`ifdef TXTMEM_CTRL_SHADOW_EN
      checks++; if (ctrlRegVal[31:0] !== 32'h0) begin errors++; $display("FAIL cr0_before_sync got=%h exp=0", ctrlRegVal[31:0]); end
      @(negedge clock) frameSync = 1'b1;
      @(negedge clock) frameSync = 1'b0;
`endif
      checks++; if (ctrlRegVal[31:0] !== 32'h5) begin errors++; $display("FAIL cr0_active got=%h exp=5", ctrlRegVal[31:0]); end
      bus_write(32'h000BFF04, 64'h77, 1'b0, a);
      bus_write(32'h000BFF24, 64'hA5A5, 1'b0, a);
`ifdef TXTMEM_CTRL_SHADOW_EN
      @(negedge clock) frameSync = 1'b1;
      @(negedge clock) frameSync = 1'b0;
`endif
      checks++; if (ctrlRegVal !== 64'h00000077_00000005) begin
         errors++; $display("FAIL ctrl_pair got=%h exp=0000007700000005", ctrlRegVal); end
      pixCellIx = 14'h1234;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(rexp[i]);
         bus_read(raddr[i], 1'b0, d, waits, got);
         exp = exp_q.pop_front();
         checks++; if (!got || d !== exp || waits != 0) begin
            errors++; $display("FAIL reg_read[%0d] got=%h waits=%0d exp=%h waits=0", i, d, waits, exp); end
         bus_release(ok);
      end
      pixCellIx = 14'h0;
`ifdef TXTMEM_CTRL_SHADOW_EN
      @(negedge clock);
      busAddr = 32'h000BFF00; busInData = 64'h9; busQW = 1'b0; busWR = 1'b1; frameSync = 1'b1;
      @(negedge clock);
      busWR = 1'b0; frameSync = 1'b0;
      checks++; if (ctrlRegVal[31:0] !== 32'h5) begin errors++; $display("FAIL sync_same_edge got=%h exp=5", ctrlRegVal[31:0]); end
      @(negedge clock) frameSync = 1'b1;
      @(negedge clock) frameSync = 1'b0;
      checks++; if (ctrlRegVal[31:0] !== 32'h9) begin errors++; $display("FAIL sync_next got=%h exp=9", ctrlRegVal[31:0]); end
`endif
   endtask

   task automatic test_font();
      logic a1, a2, a3;
      bus_write(32'h000BFF30, 64'h00430055, 1'b0, a1);
      bus_write(32'h000BFF30, 64'h00420081, 1'b0, a2);
      bus_write(32'h000BFF34, 64'h00421234, 1'b0, a3);
      checks++; if (!(a1 && a2 && a3)) begin errors++; $display("FAIL font_write_ack got=%b%b%b exp=111", a1, a2, a3); end
      @(negedge clock) fontGlyph = 16'h0243;
      repeat (3) @(negedge clock);
      checks++; if (fontData[15:0] !== 16'h0055) begin errors++; $display("FAIL font_steady got=%h exp=0055", fontData[15:0]); end
      fontGlyph = 16'h0242;
      @(negedge clock);
      checks++; if (fontData[15:0] !== 16'h0055) begin errors++; $display("FAIL font_lat1 got=%h exp=0055", fontData[15:0]); end
      @(negedge clock);
      checks++; if (fontData[31:0] !== 32'h12340081) begin errors++; $display("FAIL font_lat2 got=%h exp=12340081", fontData[31:0]); end
   endtask

   task automatic test_reset_during_wait();
      logic got; logic [63:0] d, exp; int waits; logic [1:0] ok;
      @(negedge clock);
      busAddr = 32'h000A0008; busQW = 1'b1; busWR = 1'b0; busOE = 1'b1;
      repeat (2) @(negedge clock);
      checks++; if (busOK !== 2'b10) begin errors++; $display("FAIL wait_state got=%b exp=10", busOK); end
      reset = 1'b0;
      #1;
      checks++; if (busOK !== 2'b00) begin errors++; $display("FAIL reset_immediate got=%b exp=00", busOK); end
      busOE = 1'b0; busWR = 1'b1; busInData = 64'hFFFFFFFFFFFFFFFF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checks++; if (busOK !== 2'b00 || busOutData !== 64'h0) begin
            errors++; $display("FAIL in_reset[%0d] got=%b/%h exp=00/0", i, busOK, busOutData); end
      end
      busWR = 1'b0; reset = 1'b1;
      @(negedge clock);
      checks++; if (busOK !== 2'b00) begin errors++; $display("FAIL post_reset_idle got=%b exp=00", busOK); end
      exp_q.push_back(64'h1122334455667788);
      bus_read(32'h000A0008, 1'b1, d, waits, got);
      exp = exp_q.pop_front();
      checks++; if (!got || d !== exp || waits != 2) begin
         errors++; $display("FAIL post_reset_read got=%h waits=%0d exp=%h waits=2", d, waits, exp); end
      bus_release(ok);
      checks++; if (ok !== 2'b00) begin errors++; $display("FAIL post_reset_release got=%b exp=00", ok); end
   endtask

   initial begin
      test_reset();
      test_qw();
      test_dw();
      test_back_to_back();
      test_ctrl();
      test_font();
      test_reset_during_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
